// File: rtl/vector_lane_rerouter.sv
// vector_lane_rerouter: scalar/vector lane rerouting (pass, insert, extract,
// broadcast) with a 2-entry output buffer and valid/ready handshakes.
module vector_lane_rerouter #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  mode,
  input  logic [IDX_W-1:0]            lane_idx,
  input  logic [DATA_WIDTH-1:0]       scalar_in,
  input  logic [LANES*DATA_WIDTH-1:0] vector_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] vector_out,
  output logic [DATA_WIDTH-1:0]       scalar_out,
  output logic                        idx_error
);

  localparam int VW = LANES * DATA_WIDTH;

  typedef enum logic [1:0] {
    MODE_PASS      = 2'd0,
    MODE_INSERT    = 2'd1,
    MODE_EXTRACT   = 2'd2,
    MODE_BROADCAST = 2'd3
  } mode_e;

  typedef struct packed {
    logic [VW-1:0]         vec;
    logic [DATA_WIDTH-1:0] scalar;
    logic                  err;
  } entry_t;

  entry_t      calc;
  entry_t      head;
  entry_t      tail;
  logic [1:0]  count;
  logic        idx_ok;
  logic [DATA_WIDTH-1:0] sel_lane;
  logic        push;
  logic        pop;

  // Rerouting function for the beat currently offered on the input side.
  always_comb begin
    calc.vec    = vector_in;
    calc.scalar = scalar_in;
    calc.err    = 1'b0;
    sel_lane    = '0;
    idx_ok      = ({{(32-IDX_W){1'b0}}, lane_idx} < 32'(LANES));
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_idx == IDX_W'(i)) sel_lane = vector_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
    case (mode_e'(mode))
      MODE_INSERT: begin
        if (idx_ok) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_idx == IDX_W'(i)) calc.vec[i*DATA_WIDTH +: DATA_WIDTH] = scalar_in;
          end
        end else begin
          calc.scalar = '0;
          calc.err    = 1'b1;
        end
      end
      MODE_EXTRACT: begin
        if (idx_ok) begin
          calc.vec[DATA_WIDTH-1:0] = sel_lane;
          calc.scalar              = sel_lane;
        end else begin
          calc.scalar = '0;
          calc.err    = 1'b1;
        end
      end
      MODE_BROADCAST: calc.vec = {LANES{scalar_in}};
      default: ;
    endcase
  end

  assign in_ready   = (count != 2'd2);
  assign out_valid  = (count != 2'd0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign vector_out = head.vec;
  assign scalar_out = head.scalar;
  assign idx_error  = head.err;

  // Two-entry buffer: head feeds the outputs, tail shifts into head on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= calc;
          else               tail <= calc;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        // Simultaneous push/pop only occurs at count 1: new beat replaces head.
        2'b11: head <= calc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_lane_rerouter.sv
// Testbench for vector_lane_rerouter: two instances (LANES=4 and LANES=3)
// share stimulus; a queue-based reference model scores every cycle.
module tb_vector_lane_rerouter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [1:0]   mode;
  logic [1:0]   idx;
  logic [31:0]  sin;
  logic [127:0] vin;
  logic         out_ready;

  logic         in_ready4, out_valid4, err4;
  logic [127:0] vout4;
  logic [31:0]  sout4;
  logic         in_ready3, out_valid3, err3;
  logic [95:0]  vout3;
  logic [31:0]  sout3;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [127:0] v;
    logic [31:0]  s;
    logic         e;
  } ent_t;

  ent_t q4[$];
  ent_t q3[$];

  typedef struct {
    logic [1:0]   m;
    logic [1:0]   i;
    logic [31:0]  s;
    logic [127:0] v;
    logic [127:0] ev;
    logic [31:0]  es;
    logic         ee;
  } vec_t;

  vec_t tbl[6];

  vector_lane_rerouter #(.LANES(4), .DATA_WIDTH(32)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .mode(mode), .lane_idx(idx), .scalar_in(sin), .vector_in(vin),
    .out_valid(out_valid4), .out_ready(out_ready), .vector_out(vout4),
    .scalar_out(sout4), .idx_error(err4)
  );

  vector_lane_rerouter #(.LANES(3), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .mode(mode), .lane_idx(idx), .scalar_in(sin), .vector_in(vin[95:0]),
    .out_valid(out_valid3), .out_ready(out_ready), .vector_out(vout3),
    .scalar_out(sout3), .idx_error(err3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: rules applied lane by lane on a plain vector.
  function automatic ent_t ref_op(input int lanes, input logic [1:0] m, input int i,
                                  input logic [31:0] s, input logic [127:0] v);
    ent_t r;
    r.v = v;
    r.s = s;
    r.e = 1'b0;
    if ((m == 2'd1 || m == 2'd2) && i >= lanes) begin
      r.s = '0;
      r.e = 1'b1;
    end else begin
      case (m)
        2'd1: r.v[i*32 +: 32] = s;
        2'd2: begin r.s = v[i*32 +: 32]; r.v[31:0] = r.s; end
        2'd3: for (int k = 0; k < lanes; k++) r.v[k*32 +: 32] = s;
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic model_check();
    chk("valid4", out_valid4, q4.size() != 0);
    chk("ready4", in_ready4, q4.size() != 2);
    chk("valid3", out_valid3, q3.size() != 0);
    chk("ready3", in_ready3, q3.size() != 2);
    if (q4.size() != 0) begin
      chk("vec4", vout4, q4[0].v);
      chk("sca4", sout4, q4[0].s);
      chk("err4", err4, q4[0].e);
    end
    if (q3.size() != 0) begin
      chk("vec3", {32'd0, vout3}, q3[0].v);
      chk("sca3", sout3, q3[0].s);
      chk("err3", err3, q3[0].e);
    end
  endtask

  // One clock: check at negedge, predict fires, update model at posedge.
  task automatic tick();
    bit pu, po;
    ent_t e4, e3;
    @(negedge clk);
    model_check();
    pu = in_valid && (q4.size() != 2);
    po = out_ready && (q4.size() != 0);
    e4 = ref_op(4, mode, int'(idx), sin, vin);
    e3 = ref_op(3, mode, int'(idx), sin, {32'd0, vin[95:0]});
    @(posedge clk);
    if (rst) begin
      q4.delete();
      q3.delete();
    end else begin
      if (po) begin
        void'(q4.pop_front());
        void'(q3.pop_front());
      end
      if (pu) begin
        q4.push_back(e4);
        q3.push_back(e3);
      end
    end
    #1;
  endtask

  task automatic offer(input logic [1:0] m, input logic [1:0] i, input logic [31:0] s,
                       input logic [127:0] v);
    mode = m; idx = i; sin = s; vin = v; in_valid = 1'b1;
  endtask

  initial begin
    logic [127:0] v0;
    logic [31:0]  kk;
    v0 = {32'h33, 32'h22, 32'h11, 32'h00};
    tbl[0] = '{2'd1, 2'd2, 32'hAA, v0, {32'h33, 32'hAA, 32'h11, 32'h00}, 32'hAA, 1'b0};
    tbl[1] = '{2'd2, 2'd3, 32'h0,  v0, {32'h33, 32'h22, 32'h11, 32'h33}, 32'h33, 1'b0};
    tbl[2] = '{2'd0, 2'd1, 32'h5,  v0, v0, 32'h5, 1'b0};
    tbl[3] = '{2'd3, 2'd0, 32'h77, v0, {4{32'h77}}, 32'h77, 1'b0};
    tbl[4] = '{2'd2, 2'd1, 32'h0,  v0, {32'h33, 32'h22, 32'h11, 32'h11}, 32'h11, 1'b0};
    tbl[5] = '{2'd1, 2'd0, 32'hBB, v0, {32'h33, 32'h22, 32'h11, 32'hBB}, 32'hBB, 1'b0};

    rst = 1'b1; in_valid = 1'b0; mode = '0; idx = '0; sin = '0; vin = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", out_valid4, 1'b0);
    chk("rst_ready", in_ready4, 1'b1);
    chk("rst_vec", vout4, '0);
    chk("rst_sca", sout4, '0);
    chk("rst_err", err4, 1'b0);

    // Single-beat table.
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      offer(tbl[t].m, tbl[t].i, tbl[t].s, tbl[t].v);
      tick();
      in_valid = 1'b0;
      chk("tbl_valid", out_valid4, 1'b1);
      chk("tbl_vec", vout4, tbl[t].ev);
      chk("tbl_sca", sout4, tbl[t].es);
      chk("tbl_err", err4, tbl[t].ee);
      tick();
    end

    // Out-of-range index on the 3-lane instance.
    offer(2'd1, 2'd3, 32'd9, {32'd0, 32'd7, 32'd6, 32'd5});
    tick();
    in_valid = 1'b0;
    chk("oor_ins_vec", {32'd0, vout3}, {32'd0, 32'd7, 32'd6, 32'd5});
    chk("oor_ins_sca", sout3, 32'd0);
    chk("oor_ins_err", err3, 1'b1);
    chk("oor_ins_err4", err4, 1'b0);
    offer(2'd2, 2'd3, 32'd9, {32'd0, 32'd7, 32'd6, 32'd5});
    tick();
    in_valid = 1'b0;
    chk("oor_ext_sca", sout3, 32'd0);
    chk("oor_ext_err", err3, 1'b1);
    tick();

    // Back-to-back broadcast stream.
    for (int k = 1; k <= 8; k++) begin
      kk = 32'(k);
      offer(2'd3, 2'd0, kk, '1);
      chk("bc_ready", in_ready4, 1'b1);
      tick();
      chk("bc_valid", out_valid4, 1'b1);
      chk("bc_vec", vout4, {4{kk}});
    end
    in_valid = 1'b0;
    tick();

    // Backpressure A, B, C.
    out_ready = 1'b0;
    offer(2'd0, 2'd0, 32'hA1, '0); tick();
    chk("bp_a_sca", sout4, 32'hA1);
    offer(2'd0, 2'd0, 32'hB2, '0); tick();
    chk("bp_full", in_ready4, 1'b0);
    offer(2'd0, 2'd0, 32'hC3, '0); tick();
    chk("bp_hold", sout4, 32'hA1);
    chk("bp_blocked", in_ready4, 1'b0);
    out_ready = 1'b1; tick();
    chk("bp_b_sca", sout4, 32'hB2);
    chk("bp_reopen", in_ready4, 1'b1);
    tick();
    chk("bp_c_sca", sout4, 32'hC3);
    in_valid = 1'b0; tick();
    chk("bp_empty", out_valid4, 1'b0);

    // Reset with a full buffer and a beat presented during reset.
    out_ready = 1'b0;
    offer(2'd0, 2'd0, 32'h11, '1); tick();
    offer(2'd0, 2'd0, 32'h22, '1); tick();
    rst = 1'b1;
    offer(2'd0, 2'd0, 32'h33, '1); tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_valid", out_valid4, 1'b0);
    chk("mrst_ready", in_ready4, 1'b1);
    chk("mrst_vec", vout4, '0);
    chk("mrst_sca", sout4, '0);
    chk("mrst_err", err4, 1'b0);
    out_ready = 1'b1;
    offer(2'd0, 2'd0, 32'h5A, {32'h4, 32'h3, 32'h2, 32'h1}); tick();
    in_valid = 1'b0;
    chk("mrst_pass_sca", sout4, 32'h5A);
    chk("mrst_pass_vec", vout4, {32'h4, 32'h3, 32'h2, 32'h1});
    tick();
    chk("mrst_alone", out_valid4, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      mode = 2'($urandom_range(0, 3));
      idx = 2'($urandom_range(0, 3));
      sin = $urandom;
      vin = {$urandom, $urandom, $urandom, $urandom};
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
